// File: rtl/nn_accel_pkg.sv
// Shared definitions for the accelerator datapath stages.
// Holds default sizes, the requantizer state type and a reusable saturation helper.
package nn_accel_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultN     = 3;
  localparam int unsigned DefaultAccW  = 2 * DefaultWidth;

  // Wide enough for any intermediate of a 2*WIDTH accumulator plus bias and rounding.
  localparam int unsigned SatInW = 64;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } rq_state_t;

  // Clamp a signed value to the range of a width-bit signed integer.
  function automatic logic signed [SatInW-1:0] sat_to_width(
    input logic signed [SatInW-1:0] val,
    input int unsigned              width
  );
    logic signed [SatInW-1:0] hi;
    logic signed [SatInW-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/requant_unit.sv
// Combinational requantization of one accumulator element:
// bias add, optional ReLU, round-half-up arithmetic right shift, saturate to WIDTH.
module requant_unit
  import nn_accel_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned SHIFT_W = $clog2(2 * WIDTH),
  localparam int unsigned ACC_W  = 2 * WIDTH
) (
  input  logic signed [ACC_W-1:0]   acc,
  input  logic signed [ACC_W-1:0]   bias,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu_en,
  output logic signed [WIDTH-1:0]   data
);

  // Two guard bits: one for the bias sum, one for the rounding offset.
  localparam int unsigned SumW = ACC_W + 2;

  logic signed [SumW-1:0] sum;
  logic signed [SumW-1:0] clamped;
  logic signed [SumW-1:0] half;
  logic signed [SumW-1:0] shifted;

  always_comb begin
    sum     = $signed({{2{acc[ACC_W-1]}}, acc}) + $signed({{2{bias[ACC_W-1]}}, bias});
    clamped = (relu_en && sum[SumW-1]) ? '0 : sum;
    half    = (shift == '0) ? '0 : (SumW'(1) << (shift - SHIFT_W'(1)));
    shifted = (clamped + half) >>> shift;
    data    = WIDTH'(sat_to_width($signed({{(SatInW - SumW){shifted[SumW-1]}}, shifted}),
                                  WIDTH));
  end

endmodule

// File: rtl/result_requantizer.sv
// Captures one NxN accumulator matrix plus bias/shift/relu settings and streams the
// requantized elements row-major over a valid/ready interface.
module result_requantizer
  import nn_accel_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned N       = DefaultN,
  parameter int unsigned SHIFT_W = $clog2(2 * WIDTH),
  localparam int unsigned ACC_W  = 2 * WIDTH,
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ACC_W-1:0]   resultMatrix [N][N],
  input  logic signed [ACC_W-1:0]   bias [N],
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   out_data,
  output logic        [IDX_W-1:0]   out_row,
  output logic        [IDX_W-1:0]   out_col,
  output logic                      out_last
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  rq_state_t state_q, state_d;

  logic signed [ACC_W-1:0]   mat_q [N][N];
  logic signed [ACC_W-1:0]   bias_q [N];
  logic        [SHIFT_W-1:0] shift_q;
  logic                      relu_q;

  logic [IDX_W-1:0]        row_q, row_d, col_q, col_d;
  logic [IDX_W-1:0]        nxt_row, nxt_col, sel_row, sel_col;
  logic                    valid_q, valid_d, last_q, last_d, capture;
  logic signed [WIDTH-1:0] data_q, data_d, rq_data;

  always_comb begin
    if (col_q == LastIdx) begin
      nxt_col = '0;
      nxt_row = row_q + IDX_W'(1);
    end else begin
      nxt_col = col_q + IDX_W'(1);
      nxt_row = row_q;
    end
    // PRIME loads the element at the freshly cleared index; STREAM loads the one after it.
    sel_row = (state_q == PRIME) ? row_q : nxt_row;
    sel_col = (state_q == PRIME) ? col_q : nxt_col;
  end

  requant_unit #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_requant_unit (
    .acc     (mat_q[sel_row][sel_col]),
    .bias    (bias_q[sel_col]),
    .shift   (shift_q),
    .relu_en (relu_q),
    .data    (rq_data)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = PRIME;
        end
      end
      PRIME: begin
        data_d  = rq_data;
        last_d  = (row_q == LastIdx) && (col_q == LastIdx);
        valid_d = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            row_d  = nxt_row;
            col_d  = nxt_col;
            data_d = rq_data;
            last_d = (nxt_row == LastIdx) && (nxt_col == LastIdx);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      for (int r = 0; r < N; r++) begin
        bias_q[r] <= '0;
        for (int c = 0; c < N; c++) begin
          mat_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      if (capture) begin
        mat_q   <= resultMatrix;
        bias_q  <= bias;
        shift_q <= shift;
        relu_q  <= relu_en;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_result_requantizer.sv
// Self-checking bench for result_requantizer: scoreboard of expected elements built from
// an independent integer model at capture time, drained against the DUT stream.
module tb_result_requantizer;

  localparam int NN = 3;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [31:0] rm [NN][NN];
  logic signed [31:0] bias_v [NN];
  logic [SW-1:0] shift = '0;
  logic relu_en = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic [1:0] out_row, out_col;
  logic out_last;

  typedef struct packed {
    logic signed [15:0] data;
    logic [1:0]         row;
    logic [1:0]         col;
    logic               last;
  } elem_t;

  elem_t sb[$];
  logic signed [15:0] got [NN*NN];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  result_requantizer #(
    .WIDTH   (16),
    .N       (NN),
    .SHIFT_W (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .resultMatrix (rm),
    .bias         (bias_v),
    .shift        (shift),
    .relu_en      (relu_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_last     (out_last)
  );

  function automatic logic signed [15:0] model(longint acc, longint b, int sh, bit relu);
    longint s;
    s = acc + b;
    if (relu && s < 0) s = 0;
    if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic load_seq(input int base);
    for (int r = 0; r < NN; r++)
      for (int c = 0; c < NN; c++) rm[r][c] = 32'(base + r * NN + c);
  endtask

  task automatic capture();
    elem_t e;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_ready: got %b expected 1", in_ready);
    end
    for (int r = 0; r < NN; r++)
      for (int c = 0; c < NN; c++) begin
        e.data = model(longint'(rm[r][c]), longint'(bias_v[c]), int'(shift), relu_en);
        e.row  = 2'(r);
        e.col  = 2'(c);
        e.last = (r == NN - 1) && (c == NN - 1);
        sb.push_back(e);
      end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Consume n elements using a repeating out_ready pattern of length plen.
  task automatic drain(input int n, input logic [7:0] pat, input int plen, output int cycles);
    int    got_n;
    int    k;
    bit    hold;
    elem_t exp_e, act_e, held;
    got_n = 0;
    k = 0;
    cycles = 0;
    while (got_n < n && cycles < 100) begin
      out_ready = pat[k % plen];
      k++;
      hold = 1'b0;
      act_e = '{data: out_data, row: out_row, col: out_col, last: out_last};
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL elem: got %h with empty scoreboard", act_e);
        end else begin
          exp_e = sb.pop_front();
          if (act_e !== exp_e) begin
            n_fail++;
            $display("FAIL elem %0d: got d=%0d r=%0d c=%0d l=%b expected d=%0d r=%0d c=%0d l=%b",
                     got_n, act_e.data, act_e.row, act_e.col, act_e.last,
                     exp_e.data, exp_e.row, exp_e.col, exp_e.last);
          end
        end
        got[got_n] = out_data;
        got_n++;
      end else if (out_valid === 1'b1) begin
        hold = 1'b1;
        held = act_e;
      end
      @(posedge clk); #1;
      cycles++;
      if (hold) begin
        act_e = '{data: out_data, row: out_row, col: out_col, last: out_last};
        n_checks++;
        if (act_e !== held || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL hold: got %h v=%b expected %h v=1", act_e, out_valid, held);
        end
      end
    end
    if (got_n < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d elements expected %0d", got_n, n);
    end
  endtask

  task automatic check_val(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_val("reset_outputs", {out_valid, out_data, out_row, out_col, out_last}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("reset_in_ready", in_ready, 1);
    check_val("reset_out_valid", out_valid, 0);
  endtask

  task automatic test_identity();
    int cyc;
    load_seq(1);
    out_ready = 1'b1;
    capture();
    check_val("latency_edge1", out_valid, 0);
    @(posedge clk); #1;
    check_val("latency_edge2", out_valid, 1);
    drain(9, 8'h01, 1, cyc);
    check_val("throughput_cycles", cyc, 9);
    check_val("idle_after_last", {in_ready, out_valid}, 2'b10);
    for (int i = 0; i < NN * NN; i++) check_val("identity_data", got[i], i + 1);
  endtask

  task automatic test_saturation();
    int cyc;
    load_seq(1);
    rm[0][0] = 40000;
    rm[0][1] = -40000;
    capture();
    drain(9, 8'h01, 1, cyc);
    check_val("sat_pos", got[0], 32767);
    check_val("sat_neg", got[1], -32768);
    check_val("sat_pass", got[2], 3);
    check_val("sat_pass_last", got[8], 9);
  endtask

  task automatic test_round_shift();
    int cyc;
    load_seq(100);
    rm[0][0] = 5;
    rm[0][1] = -4;
    rm[0][2] = -6;
    bias_v[1] = 10;
    shift = 2;
    capture();
    drain(9, 8'h01, 1, cyc);
    check_val("round_pos", got[0], 1);
    check_val("round_bias", got[1], 2);
    check_val("round_neg", got[2], -1);
    bias_v[1] = 0;
    shift = 0;
  endtask

  task automatic test_relu();
    int cyc;
    load_seq(-4);
    rm[0][0] = -7;
    rm[0][1] = 0;
    rm[0][2] = 3;
    relu_en = 1'b1;
    capture();
    drain(9, 8'h01, 1, cyc);
    check_val("relu_neg", got[0], 0);
    check_val("relu_zero", got[1], 0);
    check_val("relu_pos", got[2], 3);
    check_val("relu_row1", got[3], 0);
    relu_en = 1'b0;
    capture();
    drain(9, 8'h01, 1, cyc);
    check_val("norelu_neg", got[0], -7);
    check_val("norelu_pos", got[2], 3);
  endtask

  task automatic test_backpressure();
    int cyc;
    load_seq(20);
    capture();
    // Inputs change and in_valid is held high while streaming; none of it may be taken.
    load_seq(500);
    in_valid = 1'b1;
    check_val("busy_in_ready", in_ready, 0);
    drain(9, 8'b0001_1001, 5, cyc);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("no_capture_from_stream", {in_ready, out_valid}, 2'b10);
    for (int i = 0; i < NN * NN; i++) check_val("bp_data", got[i], 20 + i);
  endtask

  task automatic test_reset_mid();
    int cyc;
    load_seq(1);
    out_ready = 1'b1;
    capture();
    drain(4, 8'h01, 1, cyc);
    check_val("mid_valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_reset_outputs", {out_valid, out_data, out_row, out_col, out_last}, 0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    load_seq(10);
    capture();
    drain(9, 8'h01, 1, cyc);
    for (int i = 0; i < NN * NN; i++) check_val("post_reset_data", got[i], 10 + i);
  endtask

  initial begin
    for (int c = 0; c < NN; c++) bias_v[c] = 0;
    load_seq(0);
    test_reset();
    test_identity();
    test_saturation();
    test_round_shift();
    test_relu();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
